ptos_bus: RTL and testbench

PTOS_BUS -- requirements
Module: ptos_bus

---
 rtl/ptos_pkg.sv | 27 ++
 rtl/ptos_tick_gen.sv | 26 ++
 rtl/ptos_bus.sv | 168 ++++++++++++++++
 tb/tb_ptos_bus.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ptos_pkg.sv
// ptos_pkg: state encoding and frame-shape constants shared by the ptos_bus slice.
// The parity slot states exist only when PTOS_PARITY_EN is defined.
package ptos_pkg;

  localparam int START_TICKS = 2;
  localparam int STOP_TICKS  = 3;

  typedef enum logic [3:0] {
    IDLE,
    START,
    BIT_LO,
    BIT_HI,
`ifdef PTOS_PARITY_EN
    PAR_LO,
    PAR_HI,
`endif
    STOP_LO,
    STOP_HI,
    STOP_REL
  } state_t;

  // Bus phase ticks spent in one frame, start condition through stop release.
  function automatic int frame_ticks(input int data_w, input int par);
    return START_TICKS + 2 * data_w + 2 * par + STOP_TICKS;
  endfunction

endpackage

// File: rtl/ptos_tick_gen.sv
// ptos_tick_gen: one-cycle tick every DIV sclk cycles while enabled.
// The counter is held at zero when disabled, so the first tick lands DIV cycles after enable.
module ptos_tick_gen #(
  parameter int DIV = 2
) (
  input  logic sclk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  logic [7:0] cnt;

  assign tick = enable && (cnt == 8'(DIV - 1));

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/ptos_bus.sv
// ptos_bus: parallel-to-serial framer: start, DATA_W bits MSB first, stop, on scl/sda.
// Define PTOS_PARITY_EN to insert an even-parity bit slot after the last data bit.
module ptos_bus
  import ptos_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV    = 2
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              load,
  output logic              ack,
  output logic              busy,
  output logic              done,
  output logic              scl,
  output logic              sda
);

  localparam int CW = $clog2(DATA_W + 1);

  state_t            state, state_d;
  logic [DATA_W-1:0] shreg, shreg_d;
  logic [CW-1:0]     bitcnt, bitcnt_d;
  logic              scl_d, sda_d, busy_d, ack_d, done_d;
  logic              tick;
`ifdef PTOS_PARITY_EN
  logic              par, par_d;
`endif

  ptos_tick_gen #(.DIV(DIV)) u_tick (
    .sclk   (sclk),
    .rst    (rst),
    .enable (busy),
    .tick   (tick)
  );

  always_comb begin
    state_d  = state;
    shreg_d  = shreg;
    bitcnt_d = bitcnt;
    scl_d    = scl;
    sda_d    = sda;
    busy_d   = busy;
    ack_d    = 1'b0;
    done_d   = 1'b0;
`ifdef PTOS_PARITY_EN
    par_d    = par;
`endif
    case (state)
      IDLE: begin
        if (load) begin
          shreg_d  = data;
          bitcnt_d = '0;
          busy_d   = 1'b1;
          ack_d    = 1'b1;
          state_d  = START;
`ifdef PTOS_PARITY_EN
          par_d    = ^data;
`endif
        end
      end
      START: begin
        // sda is still high on the first tick, low on the second
        if (tick) begin
          if (sda) begin
            sda_d = 1'b0;
          end else begin
            scl_d   = 1'b0;
            state_d = BIT_LO;
          end
        end
      end
      BIT_LO: begin
        if (tick) begin
          scl_d   = 1'b0;
          sda_d   = shreg[DATA_W-1];
          state_d = BIT_HI;
        end
      end
      BIT_HI: begin
        if (tick) begin
          scl_d    = 1'b1;
          shreg_d  = shreg << 1;
          bitcnt_d = bitcnt + CW'(1);
          if (bitcnt == CW'(DATA_W - 1)) begin
`ifdef PTOS_PARITY_EN
            state_d = PAR_LO;
`else
            state_d = STOP_LO;
`endif
          end else begin
            state_d = BIT_LO;
          end
        end
      end
`ifdef PTOS_PARITY_EN
      PAR_LO: begin
        if (tick) begin
          scl_d   = 1'b0;
          sda_d   = par;
          state_d = PAR_HI;
        end
      end
      PAR_HI: begin
        if (tick) begin
          scl_d   = 1'b1;
          state_d = STOP_LO;
        end
      end
`endif
      STOP_LO: begin
        if (tick) begin
          scl_d   = 1'b0;
          sda_d   = 1'b0;
          state_d = STOP_HI;
        end
      end
      STOP_HI: begin
        if (tick) begin
          scl_d   = 1'b1;
          state_d = STOP_REL;
        end
      end
      STOP_REL: begin
        // busy drops here so a load during the done cycle is taken at once
        if (tick) begin
          sda_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      scl    <= 1'b1;
      sda    <= 1'b1;
      busy   <= 1'b0;
      ack    <= 1'b0;
      done   <= 1'b0;
`ifdef PTOS_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      state  <= state_d;
      shreg  <= shreg_d;
      bitcnt <= bitcnt_d;
      scl    <= scl_d;
      sda    <= sda_d;
      busy   <= busy_d;
      ack    <= ack_d;
      done   <= done_d;
`ifdef PTOS_PARITY_EN
      par    <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_ptos_bus.sv
// tb_ptos_bus: random and directed frames for ptos_bus, decoded from scl/sda by a monitor
// and compared against expected frames queued when each load is issued.
module tb_ptos_bus;

  localparam int W = 8;
  localparam int D = 2;
`ifdef PTOS_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME_CYC = (2 + 2 * W + 2 * P + 3) * D;
  localparam int NB        = W + P + 1;  // data bits, parity, stop-low sample

  logic         sclk = 1'b0;
  logic         rst  = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] data = '0;
  logic         ack, busy, done, scl, sda;

  ptos_bus #(.DATA_W(W), .DIV(D)) dut (
    .sclk (sclk),
    .rst  (rst),
    .data (data),
    .load (load),
    .ack  (ack),
    .busy (busy),
    .done (done),
    .scl  (scl),
    .sda  (sda)
  );

  always #5 sclk = ~sclk;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];
  int          ack_q[$];
  int          done_seen = 0;
  int          sent = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Serial sequence seen on scl rises: data MSB first, optional even parity, stop-low 0.
  function automatic logic [63:0] frame_bits(input logic [W-1:0] d);
    logic [63:0] v;
    v = 64'(d);
    if (P == 1) v = (v << 1) | 64'($countones(d) % 2);
    return v << 1;
  endfunction

  // Monitor
  logic        p_scl = 1'b1, p_sda = 1'b1, p_busy = 1'b0, p_ack = 1'b0;
  bit          in_frame = 0;
  int          nbits = 0;
  logic [63:0] rx = '0;
  logic [63:0] exp_v;
  int          busy_cnt = 0;

  always @(negedge sclk) begin
    if (!rst) begin
      in_frame = 0;
      nbits    = 0;
      busy_cnt = 0;
      p_busy   = 1'b0;
      p_scl    = 1'b1;
      p_sda    = 1'b1;
      p_ack    = 1'b0;
    end else begin
      if (!in_frame) begin
        if (p_scl && scl && p_sda && !sda) begin
          in_frame = 1;
          nbits    = 0;
          rx       = '0;
        end
      end else if (!p_scl && scl) begin
        rx = (rx << 1) | 64'(sda);
        nbits++;
      end else if (p_scl && scl) begin
        if (!p_sda && sda) begin
          in_frame = 0;
          check("bit_count", 64'(nbits), 64'(NB));
          check("frame_pending", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            check("frame_bits", rx, exp_v);
          end
        end else begin
          check("sda_stable_scl_high", 64'(sda), 64'(p_sda));
        end
      end

      if (busy) begin
        busy_cnt++;
      end else if (p_busy) begin
        check("busy_len", 64'(busy_cnt), 64'(FRAME_CYC));
        check("done_at_end", 64'(done), 64'd1);
        busy_cnt = 0;
      end
      if (done) begin
        check("done_aligned", 64'(p_busy && !busy), 64'd1);
        done_seen++;
      end

      if (ack) begin
        check("ack_expected", 64'(ack_q.size() > 0), 64'd1);
        if (ack_q.size() > 0) void'(ack_q.pop_front());
        check("ack_width", 64'(p_ack), 64'd0);
        check("busy_with_ack", 64'(busy), 64'd1);
      end

      p_scl  = scl;
      p_sda  = sda;
      p_busy = busy;
      p_ack  = ack;
    end
  end

  // Stimulus (all calls start at a negedge)
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(negedge sclk);
      n++;
    end
    check("idle_reached", 64'(busy), 64'd0);
  endtask

  task automatic send(input logic [W-1:0] d);
    wait_idle();
    data = d;
    load = 1'b1;
    exp_q.push_back(frame_bits(d));
    ack_q.push_back(1);
    sent++;
    @(negedge sclk);
    load = 1'b0;
    data = W'($urandom);
  endtask

  task automatic wait_ack();
    int n;
    n = 0;
    do begin
      @(negedge sclk);
      n++;
    end while (ack !== 1'b1 && n < 400);
    check("ack_seen", 64'(ack), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d;
    int           n;

    @(negedge sclk);
    check("rst_scl", 64'(scl), 64'd1);
    check("rst_sda", 64'(sda), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(negedge sclk);
    rst = 1'b1;
    repeat (2) @(negedge sclk);

    send(8'hA5);
    send(8'h07);
    send(8'h00);
    send(8'hFF);

    for (int i = 0; i < 20; i++) begin
      d = W'($urandom);
      send(d);
      if ($urandom_range(1, 0) == 1) begin
        repeat ($urandom_range(30, 2)) @(negedge sclk);
        load = 1'b1;
        data = W'($urandom);
        @(negedge sclk);
        load = 1'b0;
      end
      repeat ($urandom_range(3, 0)) @(negedge sclk);
    end

    // load held high across the done cycle: second frame captured with no extra idle
    wait_idle();
    data = 8'h5A;
    load = 1'b1;
    exp_q.push_back(frame_bits(8'h5A));
    ack_q.push_back(1);
    sent++;
    wait_ack();
    data = 8'hC3;
    exp_q.push_back(frame_bits(8'hC3));
    ack_q.push_back(1);
    sent++;
    n = 0;
    do begin
      @(negedge sclk);
      n++;
    end while (done !== 1'b1 && n < 400);
    check("b2b_done_seen", 64'(done), 64'd1);
    @(negedge sclk);
    check("b2b_ack_next_cycle", 64'(ack), 64'd1);
    check("b2b_busy_next_cycle", 64'(busy), 64'd1);
    load = 1'b0;

    // reset during bit 3 aborts the frame
    send(W'($urandom));
    n = 0;
    while (nbits < 3 && n < 400) begin
      @(negedge sclk);
      n++;
    end
    check("bit3_reached", 64'(nbits >= 3), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("abort_scl", 64'(scl), 64'd1);
    check("abort_sda", 64'(sda), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge sclk);
    exp_q.delete();
    sent--;
    rst = 1'b1;
    @(negedge sclk);
    send(8'h3C);

    wait_idle();
    repeat (4) @(negedge sclk);
    check("frames_drained", 64'(exp_q.size()), 64'd0);
    check("acks_drained", 64'(ack_q.size()), 64'd0);
    check("done_count", 64'(done_seen), 64'(sent));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
